// File: rtl/logic_sweep_cmp_pkg.sv
// Shared opcodes and FSM state encoding for the logic sweep comparator.
package logic_sweep_cmp_pkg;

  localparam int OPW = 3;

  localparam logic [OPW-1:0] OP_ANDN = 3'd0;  // A & ~B
  localparam logic [OPW-1:0] OP_ORN  = 3'd1;  // A | ~B
  localparam logic [OPW-1:0] OP_XOR  = 3'd2;  // A ^ B
  localparam logic [OPW-1:0] OP_NAND = 3'd3;  // ~(A & B)
  localparam logic [OPW-1:0] OP_AND  = 3'd4;  // A & B
  localparam logic [OPW-1:0] OP_OR   = 3'd5;  // A | B
  localparam logic [OPW-1:0] OP_NOR  = 3'd6;  // ~(A | B)
  localparam logic [OPW-1:0] OP_XNOR = 3'd7;  // ~(A ^ B)

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

endpackage

// File: rtl/logic_sweep_cmp_op_eval.sv
// Combinational W-bit bitwise function selected by a 3-bit opcode.
module logic_op_eval
  import logic_sweep_cmp_pkg::*;
#(
  parameter int W = 1
) (
  input  logic [OPW-1:0] i_op,
  input  logic [W-1:0]   i_a,
  input  logic [W-1:0]   i_b,
  output logic [W-1:0]   o_s
);

  // Decode the opcode into one of the eight bitwise functions.
  always_comb begin
    o_s = '0;
    case (i_op)
      OP_ANDN: o_s = i_a & ~i_b;
      OP_ORN:  o_s = i_a | ~i_b;
      OP_XOR:  o_s = i_a ^ i_b;
      OP_NAND: o_s = ~(i_a & i_b);
      OP_AND:  o_s = i_a & i_b;
      OP_OR:   o_s = i_a | i_b;
      OP_NOR:  o_s = ~(i_a | i_b);
      OP_XNOR: o_s = ~(i_a ^ i_b);
      default: o_s = '0;
    endcase
  end

endmodule

// File: rtl/logic_sweep_cmp.sv
// Sweeps every {A,B} combination, streams f_x/f_y per row and tracks mismatches.
module logic_sweep_cmp
  import logic_sweep_cmp_pkg::*;
#(
  parameter int W = 1
) (
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic             i_start,
  input  logic             i_abort,
  input  logic             i_hold,
  input  logic [OPW-1:0]   i_op_x,
  input  logic [OPW-1:0]   i_op_y,
  output logic             o_busy,
  output logic             o_done,
  output logic             o_row_valid,
  output logic [2*W-1:0]   o_row_idx,
  output logic [W-1:0]     o_row_a,
  output logic [W-1:0]     o_row_b,
  output logic [W-1:0]     o_row_sx,
  output logic [W-1:0]     o_row_sy,
  output logic [2*W:0]     o_mis_cnt,
  output logic             o_mis_any,
  output logic [2*W-1:0]   o_mis_first
);

  localparam int IW = 2 * W;
  localparam logic [IW-1:0] LAST_IDX = {IW{1'b1}};

  state_t           r_state;
  logic [OPW-1:0]   r_op_x;
  logic [OPW-1:0]   r_op_y;
  logic [IW-1:0]    r_idx;
  logic             r_busy;
  logic             r_done;
  logic             r_row_valid;
  logic [IW-1:0]    r_row_idx;
  logic [W-1:0]     r_row_a;
  logic [W-1:0]     r_row_b;
  logic [W-1:0]     r_row_sx;
  logic [W-1:0]     r_row_sy;
  logic [IW:0]      r_mis_cnt;
  logic             r_mis_any;
  logic [IW-1:0]    r_mis_first;

  logic [W-1:0]     w_a;
  logic [W-1:0]     w_b;
  logic [W-1:0]     w_sx;
  logic [W-1:0]     w_sy;
  logic             w_mis;

  // A occupies the upper half of the row index.
  assign w_a   = r_idx[IW-1:W];
  assign w_b   = r_idx[W-1:0];
  assign w_mis = (w_sx != w_sy);

  logic_op_eval #(.W(W)) u_eval_x (
    .i_op (r_op_x),
    .i_a  (w_a),
    .i_b  (w_b),
    .o_s  (w_sx)
  );

  logic_op_eval #(.W(W)) u_eval_y (
    .i_op (r_op_y),
    .i_a  (w_a),
    .i_b  (w_b),
    .o_s  (w_sy)
  );

  // Sweep FSM: owns the index counter, row outputs and mismatch tracking.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_state     <= S_IDLE;
      r_op_x      <= '0;
      r_op_y      <= '0;
      r_idx       <= '0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_row_valid <= 1'b0;
      r_row_idx   <= '0;
      r_row_a     <= '0;
      r_row_b     <= '0;
      r_row_sx    <= '0;
      r_row_sy    <= '0;
      r_mis_cnt   <= '0;
      r_mis_any   <= 1'b0;
      r_mis_first <= '0;
    end else begin
      r_done      <= 1'b0;
      r_row_valid <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (i_start) begin
            r_op_x      <= i_op_x;
            r_op_y      <= i_op_y;
            r_idx       <= '0;
            r_mis_cnt   <= '0;
            r_mis_any   <= 1'b0;
            r_mis_first <= '0;
            r_busy      <= 1'b1;
            r_state     <= S_RUN;
          end
        end
        S_RUN: begin
          if (i_abort) begin
            // Partial mismatch results are deliberately kept.
            r_busy  <= 1'b0;
            r_state <= S_IDLE;
          end else if (!i_hold) begin
            r_row_valid <= 1'b1;
            r_row_idx   <= r_idx;
            r_row_a     <= w_a;
            r_row_b     <= w_b;
            r_row_sx    <= w_sx;
            r_row_sy    <= w_sy;
            if (w_mis) begin
              r_mis_cnt <= r_mis_cnt + (IW+1)'(1);
              if (!r_mis_any) begin
                r_mis_any   <= 1'b1;
                r_mis_first <= r_idx;
              end
            end
            r_idx <= r_idx + IW'(1);
            if (r_idx == LAST_IDX) begin
              r_done  <= 1'b1;
              r_state <= S_DONE;
            end
          end
        end
        S_DONE: begin
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
        default: begin
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign o_busy      = r_busy;
  assign o_done      = r_done;
  assign o_row_valid = r_row_valid;
  assign o_row_idx   = r_row_idx;
  assign o_row_a     = r_row_a;
  assign o_row_b     = r_row_b;
  assign o_row_sx    = r_row_sx;
  assign o_row_sy    = r_row_sy;
  assign o_mis_cnt   = r_mis_cnt;
  assign o_mis_any   = r_mis_any;
  assign o_mis_first = r_mis_first;

endmodule

// File: tb/tb_logic_sweep_cmp.sv
// Directed bench for logic_sweep_cmp with W=1 and W=2 instances.
module tb_logic_sweep_cmp;

  logic       clk = 1'b0;
  logic       reset;
  logic       start;
  logic       abort;
  logic       hold;
  logic [2:0] op_x;
  logic [2:0] op_y;
  int         sel;

  logic       d1_start, d2_start;

  logic       d1_busy, d1_done, d1_row_valid, d1_mis_any;
  logic [1:0] d1_row_idx, d1_mis_first;
  logic       d1_row_a, d1_row_b, d1_row_sx, d1_row_sy;
  logic [2:0] d1_mis_cnt;

  logic       d2_busy, d2_done, d2_row_valid, d2_mis_any;
  logic [3:0] d2_row_idx, d2_mis_first;
  logic [1:0] d2_row_a, d2_row_b, d2_row_sx, d2_row_sy;
  logic [4:0] d2_mis_cnt;

  int m_busy, m_done, m_valid, m_idx, m_a, m_b, m_sx, m_sy, m_cnt, m_any, m_first;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  assign d1_start = start & (sel == 1);
  assign d2_start = start & (sel == 2);

  logic_sweep_cmp #(.W(1)) dut1 (
    .i_clk(clk), .i_reset(reset), .i_start(d1_start), .i_abort(abort), .i_hold(hold),
    .i_op_x(op_x), .i_op_y(op_y), .o_busy(d1_busy), .o_done(d1_done),
    .o_row_valid(d1_row_valid), .o_row_idx(d1_row_idx), .o_row_a(d1_row_a),
    .o_row_b(d1_row_b), .o_row_sx(d1_row_sx), .o_row_sy(d1_row_sy),
    .o_mis_cnt(d1_mis_cnt), .o_mis_any(d1_mis_any), .o_mis_first(d1_mis_first)
  );

  logic_sweep_cmp #(.W(2)) dut2 (
    .i_clk(clk), .i_reset(reset), .i_start(d2_start), .i_abort(abort), .i_hold(hold),
    .i_op_x(op_x), .i_op_y(op_y), .o_busy(d2_busy), .o_done(d2_done),
    .o_row_valid(d2_row_valid), .o_row_idx(d2_row_idx), .o_row_a(d2_row_a),
    .o_row_b(d2_row_b), .o_row_sx(d2_row_sx), .o_row_sy(d2_row_sy),
    .o_mis_cnt(d2_mis_cnt), .o_mis_any(d2_mis_any), .o_mis_first(d2_mis_first)
  );

  always_comb begin
    if (sel == 1) begin
      m_busy = int'(d1_busy);     m_done = int'(d1_done);   m_valid = int'(d1_row_valid);
      m_idx  = int'(d1_row_idx);  m_a    = int'(d1_row_a);  m_b     = int'(d1_row_b);
      m_sx   = int'(d1_row_sx);   m_sy   = int'(d1_row_sy); m_cnt   = int'(d1_mis_cnt);
      m_any  = int'(d1_mis_any);  m_first = int'(d1_mis_first);
    end else begin
      m_busy = int'(d2_busy);     m_done = int'(d2_done);   m_valid = int'(d2_row_valid);
      m_idx  = int'(d2_row_idx);  m_a    = int'(d2_row_a);  m_b     = int'(d2_row_b);
      m_sx   = int'(d2_row_sx);   m_sy   = int'(d2_row_sy); m_cnt   = int'(d2_mis_cnt);
      m_any  = int'(d2_mis_any);  m_first = int'(d2_mis_first);
    end
  end

  typedef struct {
    int w;
    int opx;
    int opy;
    int hs;         // first cycle with hold=1
    int hl;         // number of hold cycles (0 = none)
    int mid_start;  // cycle at which start is re-pulsed (-1 = none)
    int exp_done;
    int exp_rows;
    int exp_mis;
    int exp_any;
    int exp_first;
  } vec_t;

  task automatic chk(input string name, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int fmodel(input int op, input int a, input int b, input int w);
    int msk;
    int r;
    msk = (1 << w) - 1;
    case (op)
      0: r = a & ~b;
      1: r = a | ~b;
      2: r = a ^ b;
      3: r = ~(a & b);
      4: r = a & b;
      5: r = a | b;
      6: r = ~(a | b);
      default: r = ~(a ^ b);
    endcase
    return r & msk;
  endfunction

  task automatic run_vec(input vec_t v);
    int cyc;
    int row;
    int done_cyc;
    int msk;
    msk = (1 << v.w) - 1;
    sel = v.w;
    op_x = 3'(v.opx);
    op_y = 3'(v.opy);
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    cyc = 1;
    row = 0;
    done_cyc = -1;
    while (done_cyc < 0 && cyc < 60) begin
      if (cyc == 1) chk("busy_after_start", m_busy, 1);
      if (v.hl > 0 && cyc > v.hs && cyc <= v.hs + v.hl) chk("stall_valid", m_valid, 0);
      if (m_valid != 0) begin
        chk("row_idx", m_idx, row);
        chk("row_a", m_a, row >> v.w);
        chk("row_b", m_b, row & msk);
        chk("row_sx", m_sx, fmodel(v.opx, row >> v.w, row & msk, v.w));
        chk("row_sy", m_sy, fmodel(v.opy, row >> v.w, row & msk, v.w));
        row++;
      end
      if (m_done != 0) begin
        done_cyc = cyc;
        chk("done_with_valid", m_valid, 1);
        chk("busy_in_done", m_busy, 1);
      end
      hold  = (v.hl > 0 && cyc >= v.hs && cyc < v.hs + v.hl);
      start = (cyc == v.mid_start);
      @(negedge clk);
      cyc++;
    end
    hold  = 1'b0;
    start = 1'b0;
    chk("done_cycle", done_cyc, v.exp_done);
    chk("rows_emitted", row, v.exp_rows);
    chk("mis_cnt", m_cnt, v.exp_mis);
    chk("mis_any", m_any, v.exp_any);
    chk("mis_first", m_first, v.exp_first);
    // Now one cycle past DONE: back to idle, results held.
    chk("post_done_busy", m_busy, 0);
    chk("post_done_pulse", m_done, 0);
    chk("post_done_valid", m_valid, 0);
    chk("held_mis_cnt", m_cnt, v.exp_mis);
  endtask

  vec_t vecs[5];

  initial begin
    vecs[0] = '{1, 0, 1, 0, 0, -1,  5,  4,  2, 1, 0};
    vecs[1] = '{1, 4, 4, 0, 0, -1,  5,  4,  0, 0, 0};
    vecs[2] = '{2, 2, 7, 0, 0, -1, 17, 16, 16, 1, 0};
    vecs[3] = '{1, 0, 1, 3, 3,  5,  8,  4,  2, 1, 0};
    vecs[4] = '{2, 4, 2, 0, 0, -1, 17, 16, 15, 1, 1};

    reset = 1'b1;
    start = 1'b0;
    abort = 1'b0;
    hold  = 1'b0;
    op_x  = 3'd0;
    op_y  = 3'd0;
    sel   = 1;
    #1;
    chk("rst1_busy", m_busy, 0);
    chk("rst1_valid", m_valid, 0);
    chk("rst1_cnt", m_cnt, 0);
    sel = 2;
    #1;
    chk("rst2_busy", m_busy, 0);
    chk("rst2_first", m_first, 0);
    @(negedge clk);
    reset = 1'b0;

    for (int i = 0; i < 5; i++) run_vec(vecs[i]);

    // Abort while row 3 would be processed.
    sel  = 2;
    op_x = 3'd5;
    op_y = 3'd6;
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int c = 1; c <= 5; c++) begin
      if (c >= 2 && c <= 4) begin
        chk("abort_row_valid", m_valid, 1);
        chk("abort_row_idx", m_idx, c - 2);
      end
      if (c == 4) abort = 1'b1;
      if (c == 5) begin
        abort = 1'b0;
        chk("abort_valid", m_valid, 0);
        chk("abort_done", m_done, 0);
        chk("abort_busy", m_busy, 0);
        chk("abort_mis_cnt", m_cnt, 3);
        chk("abort_mis_any", m_any, 1);
      end
      if (c < 5) @(negedge clk);
    end
    @(negedge clk);
    chk("abort_no_done", m_done, 0);
    chk("abort_idle_busy", m_busy, 0);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("restart_clear_cnt", m_cnt, 0);
    chk("restart_busy", m_busy, 1);

    // Asynchronous reset mid-run, sampled before the next clock edge.
    repeat (4) @(negedge clk);
    #2;
    reset = 1'b1;
    #1;
    chk("arst_busy", m_busy, 0);
    chk("arst_valid", m_valid, 0);
    chk("arst_idx", m_idx, 0);
    chk("arst_cnt", m_cnt, 0);
    chk("arst_any", m_any, 0);
    @(negedge clk);
    reset = 1'b0;
    run_vec('{2, 5, 6, 0, 0, -1, 17, 16, 16, 1, 0});

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/logic_sweep_cmp.md
Name: logic_sweep_cmp

Overview:
Parametrised sequential successor to the hand-written two-input truth-table exercises. It sweeps every combination of two W-bit operands A and B and evaluates two selectable bitwise functions (op_x, op_y) on each row. Each row is streamed out, and mismatching rows are counted, so two candidate implementations can be checked against each other automatically. It sits beside the guide exercises as a reusable equivalence and sweep engine driven by a bench or a small controller.

Parameters:
W, 1, operand width in bits; rows = 2^(2W), row index = {A,B} with A in the upper W bits
OPW, 3, opcode width; fixed at 3, so 8 operations

Ports:
clk  input  1  rising-edge clock
reset  input  1  asynchronous, active-high reset
start  input  1  one-cycle request; accepted only in IDLE
abort  input  1  synchronous; returns to IDLE from RUN without done
hold  input  1  in RUN, stalls the sweep for this cycle
op_x  input  3  opcode of function X; latched at start
op_y  input  3  opcode of function Y; latched at start
busy  output  1  high in RUN and DONE
done  output  1  one-cycle pulse, sweep complete
row_valid  output  1  row_* outputs valid this cycle
row_idx  output  2W  index of the emitted row
row_a  output  W  operand A of the row
row_b  output  W  operand B of the row
row_sx  output  W  f_x(A,B)
row_sy  output  W  f_y(A,B)
mis_cnt  output  2W+1  count of rows where sx != sy
mis_any  output  1  at least one mismatch seen
mis_first  output  2W  index of the first mismatching row

Behaviour:
- Opcodes, all bitwise: 0 A&~B, 1 A|~B, 2 A^B, 3 ~(A&B), 4 A&B, 5 A|B, 6 ~(A|B), 7 ~(A^B).
- Reset clears every output and register to 0 and sets state to IDLE, regardless of the current state.
- States: IDLE, RUN, DONE.
- IDLE:
  - start=1 latches op_x/op_y, clears idx, mis_cnt, mis_any and mis_first, and moves to RUN.
  - start is ignored in RUN and DONE.
- RUN, cycle with hold=0 and abort=0:
  - At the next edge, row_idx/a/b/sx/sy are registered from idx and row_valid=1.
  - If sx!=sy, mis_cnt increments; on the first mismatch, mis_first=idx and mis_any=1.
  - idx increments.
- RUN, cycle with hold=1: idx frozen, row_valid=0 at the next edge.
- RUN, last row (idx = rows-1) processed: the next state is DONE. The last row's row_valid and done=1 are in the same cycle.
- DONE: lasts exactly one cycle, then IDLE.
- abort=1 in RUN:
  - Next state IDLE, row_valid=0, done is never pulsed.
  - mis_* keep their partial values.
  - abort has priority over hold.
- Latency: start accepted at cycle 0; row 0 valid at cycle 2; with no hold, done at cycle rows+1.
- mis_* hold their values after DONE until the next accepted start.
- mis_cnt is 2W+1 bits wide so that the value rows fits without wrap.
- busy is registered: 1 from the cycle after start through the DONE cycle.

Decomposition:
- Shared package / include holds:
  - opcode localparams OP_ANDN … OP_XNOR
  - state encodings S_IDLE, S_RUN, S_DONE
- Sub-module logic_op_eval:
  - parameter W; ports op, a, b → s; purely combinational case on op.
  - Instantiated twice (X and Y).
- Top contains the FSM, index counter and mismatch tracking.

Test Plan:
- W=1, op_x=0, op_y=1, start, no hold:
  - rows (a,b,sx,sy): 0:(0,0,0,1), 1:(0,1,0,0), 2:(1,0,1,1), 3:(1,1,0,1)
  - done at cycle 5; mis_cnt=2, mis_any=1, mis_first=0
- W=1, op_x=4, op_y=4 → 4 rows, mis_cnt=0, mis_any=0, mis_first=0, done at cycle 5.
- W=2, op_x=2, op_y=7 → 16 rows, every row mismatches; mis_cnt=5'b10000, mis_first=0, done at cycle 17.
- W=1, op_x=0, op_y=1:
  - hold=1 for 3 cycles after row 1 is emitted → no row_valid during the stall, rows resume at idx 2, done at cycle 8.
  - start pulsed mid-run → ignored.
- Abort and reset:
  - W=2, op_x=5, op_y=6: abort at the cycle row 3 is processed → IDLE next cycle, no done, mis_cnt=3, busy=0; a new start clears mis_cnt.
  - Reset asserted asynchronously mid-RUN → all outputs 0 immediately; a subsequent start completes a normal full sweep.
